// File: rtl/cpu_exc_pkg.sv
// Shared types and constants for the exception/interrupt sequencer.
package cpu_exc_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam logic [31:0] IRQ_VECTOR_DEF = 32'h8000_0004;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0008;
   localparam logic [4:0]  XP_REG_DEF     = 5'd26;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ABORT    = 3'd1,
      ST_SAVE     = 3'd2,
      ST_REDIRECT = 3'd3,
      ST_HANDLER  = 3'd4
   } state_e;

   // Cause encoding, shared with the optional cause_code output
   typedef enum logic [1:0] {
      CAUSE_NONE   = 2'b00,
      CAUSE_IRQ    = 2'b01,
      CAUSE_UNDEF  = 2'b10,
      CAUSE_DFAULT = 2'b11
   } cause_e;

endpackage

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer: takes an irq or undefined-instruction trap,
// sequences abort / error-target + EPC save / PC redirect, then waits for ERET.
// Optional macro EXC_CAUSE_EN adds cause_code/cause_write outputs.
module exc_sequencer
   import cpu_exc_pkg::*;
#(
   parameter int unsigned        ADDR_W     = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0]  IRQ_VECTOR = ADDR_W'(IRQ_VECTOR_DEF),
   parameter logic [ADDR_W-1:0]  EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEF),
   parameter logic [4:0]         XP_REG     = XP_REG_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              irq,
   input  logic              undef_inst,
   input  logic              instr_boundary,
   input  logic              kernel_mode,
   input  logic              eret,
   output logic              er_write,
   output logic [4:0]        er_target,
   output logic              epc_write,
   output logic              abort,
   output logic              pc_sel_exc,
   output logic [ADDR_W-1:0] handler_pc,
   output logic              irq_ack,
   output logic              busy,
   output logic              double_fault
`ifdef EXC_CAUSE_EN
   ,
   output logic [1:0]        cause_code,
   output logic              cause_write
`endif
);

   state_e            state_q, state_d;
   cause_e            cause_q, cause_d;
   logic              irq_pend_q, irq_pend_d;
   logic              double_fault_q, double_fault_d;
   logic              abort_q, abort_d;
   logic              er_write_q, er_write_d;
   logic [4:0]        er_target_q, er_target_d;
   logic              epc_write_q, epc_write_d;
   logic              pc_sel_q, pc_sel_d;
   logic [ADDR_W-1:0] handler_pc_q, handler_pc_d;
   logic              irq_ack_q, irq_ack_d;
   logic              busy_q, busy_d;
`ifdef EXC_CAUSE_EN
   logic [1:0]        cause_code_q, cause_code_d;
   logic              cause_write_q, cause_write_d;
`endif

   // State, pending-irq latch, sticky fault and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         cause_q        <= CAUSE_NONE;
         irq_pend_q     <= 1'b0;
         double_fault_q <= 1'b0;
         abort_q        <= 1'b0;
         er_write_q     <= 1'b0;
         er_target_q    <= '0;
         epc_write_q    <= 1'b0;
         pc_sel_q       <= 1'b0;
         handler_pc_q   <= '0;
         irq_ack_q      <= 1'b0;
         busy_q         <= 1'b0;
`ifdef EXC_CAUSE_EN
         cause_code_q   <= 2'b00;
         cause_write_q  <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         cause_q        <= cause_d;
         irq_pend_q     <= irq_pend_d;
         double_fault_q <= double_fault_d;
         abort_q        <= abort_d;
         er_write_q     <= er_write_d;
         er_target_q    <= er_target_d;
         epc_write_q    <= epc_write_d;
         pc_sel_q       <= pc_sel_d;
         handler_pc_q   <= handler_pc_d;
         irq_ack_q      <= irq_ack_d;
         busy_q         <= busy_d;
`ifdef EXC_CAUSE_EN
         cause_code_q   <= cause_code_d;
         cause_write_q  <= cause_write_d;
`endif
      end
   end

   // Next state, and outputs decoded from the next state so they line up with it
   always_comb begin
      state_d        = state_q;
      cause_d        = cause_q;
      double_fault_d = double_fault_q;
      // A level irq still high during the ack cycle keeps the request pending
      irq_pend_d     = irq | (irq_pend_q & ~irq_ack_q);

      case (state_q)
         ST_IDLE: begin
            if (undef_inst && !kernel_mode) begin
               state_d = ST_ABORT;
               cause_d = CAUSE_UNDEF;
            end else if (irq_pend_q && instr_boundary && !kernel_mode) begin
               state_d = ST_ABORT;
               cause_d = CAUSE_IRQ;
            end
            if (undef_inst && kernel_mode) begin
               double_fault_d = 1'b1;
            end
         end
         ST_ABORT:    state_d = ST_SAVE;
         ST_SAVE:     state_d = ST_REDIRECT;
         ST_REDIRECT: state_d = ST_HANDLER;
         ST_HANDLER: begin
            if (eret) begin
               state_d = ST_IDLE;
               cause_d = CAUSE_NONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cause_d = CAUSE_NONE;
         end
      endcase

      abort_d      = (state_d == ST_ABORT) || (state_d == ST_SAVE);
      er_write_d   = (state_d == ST_SAVE);
      er_target_d  = (state_d == ST_SAVE) ? XP_REG : 5'd0;
      epc_write_d  = (state_d == ST_SAVE);
      irq_ack_d    = (state_d == ST_SAVE) && (cause_d == CAUSE_IRQ);
      pc_sel_d     = (state_d == ST_REDIRECT);
      handler_pc_d = '0;
      if (state_d == ST_REDIRECT) begin
         handler_pc_d = (cause_d == CAUSE_IRQ) ? IRQ_VECTOR : EXC_VECTOR;
      end
      busy_d       = (state_d != ST_IDLE);
`ifdef EXC_CAUSE_EN
      cause_write_d = (state_d == ST_SAVE);
      cause_code_d  = 2'b00;
      if (double_fault_d) begin
         cause_code_d = 2'(CAUSE_DFAULT);
      end else if (state_d == ST_SAVE) begin
         cause_code_d = 2'(cause_d);
      end
`endif
   end

   assign abort        = abort_q;
   assign er_write     = er_write_q;
   assign er_target    = er_target_q;
   assign epc_write    = epc_write_q;
   assign pc_sel_exc   = pc_sel_q;
   assign handler_pc   = handler_pc_q;
   assign irq_ack      = irq_ack_q;
   assign busy         = busy_q;
   assign double_fault = double_fault_q;
`ifdef EXC_CAUSE_EN
   assign cause_code   = cause_code_q;
   assign cause_write  = cause_write_q;
`endif

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed table-driven bench for exc_sequencer plus reset corner sequences.
module tb_exc_sequencer;

   logic        clk;
   logic        reset;
   logic        irq, undef_inst, instr_boundary, kernel_mode, eret;
   logic        er_write, epc_write, abort, pc_sel_exc, irq_ack, busy, double_fault;
   logic [4:0]  er_target;
   logic [31:0] handler_pc;
`ifdef EXC_CAUSE_EN
   logic [1:0]  cause_code;
   logic        cause_write;
`endif

   int n_total = 0;
   int n_pass  = 0;

   exc_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .irq            (irq),
      .undef_inst     (undef_inst),
      .instr_boundary (instr_boundary),
      .kernel_mode    (kernel_mode),
      .eret           (eret),
      .er_write       (er_write),
      .er_target      (er_target),
      .epc_write      (epc_write),
      .abort          (abort),
      .pc_sel_exc     (pc_sel_exc),
      .handler_pc     (handler_pc),
      .irq_ack        (irq_ack),
      .busy           (busy),
      .double_fault   (double_fault)
`ifdef EXC_CAUSE_EN
      ,
      .cause_code     (cause_code),
      .cause_write    (cause_write)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flag bit order: {busy, abort, er_write, epc_write, pc_sel_exc, irq_ack, double_fault}
   localparam logic [6:0] F_BUSY = 7'b1000000;
   localparam logic [6:0] F_AB   = 7'b0100000;
   localparam logic [6:0] F_ERW  = 7'b0010000;
   localparam logic [6:0] F_EPC  = 7'b0001000;
   localparam logic [6:0] F_PCS  = 7'b0000100;
   localparam logic [6:0] F_ACK  = 7'b0000010;
   localparam logic [6:0] F_DF   = 7'b0000001;
   localparam logic [6:0] S_ABORT = F_BUSY | F_AB;
   localparam logic [6:0] S_SAVE  = F_BUSY | F_AB | F_ERW | F_EPC;
   localparam logic [6:0] S_REDIR = F_BUSY | F_PCS;
   localparam logic [6:0] S_HAND  = F_BUSY;
   localparam logic [31:0] V_IRQ = 32'h8000_0004;
   localparam logic [31:0] V_EXC = 32'h8000_0008;

   typedef struct {
      logic        irq, undef, bnd, kern, eret;
      logic [6:0]  flags;
      logic [31:0] hpc;
      logic [1:0]  cc;
      logic        cw;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic i, logic u, logic b, logic k, logic e,
                               logic [6:0] f, logic [31:0] h, logic [1:0] c, logic w);
      vec_t v;
      v.irq = i; v.undef = u; v.bnd = b; v.kern = k; v.eret = e;
      v.flags = f; v.hpc = h; v.cc = c; v.cw = w;
      return v;
   endfunction

   function automatic logic [6:0] flags_now();
      return {busy, abort, er_write, epc_write, pc_sel_exc, irq_ack, double_fault};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   task automatic drive(input logic i, input logic u, input logic b, input logic k, input logic e);
      irq = i; undef_inst = u; instr_boundary = b; kernel_mode = k; eret = e;
   endtask

   task automatic chk_idle(input string name);
      chk({name, " flags"}, 32'(flags_now()), 32'd0);
      chk({name, " er_target"}, 32'(er_target), 32'd0);
      chk({name, " handler_pc"}, handler_pc, 32'd0);
   endtask

   initial begin
      // Interrupt taken at boundary, then handler
      vecs.push_back(mk(0,0,0,0,0, 7'd0,          0,     2'b00, 0)); // 0 pending irq, no boundary
      vecs.push_back(mk(1,0,0,0,0, 7'd0,          0,     2'b00, 0)); // 1
      vecs.push_back(mk(0,0,0,0,0, 7'd0,          0,     2'b00, 0)); // 2
      vecs.push_back(mk(0,0,1,0,0, S_ABORT,       0,     2'b00, 0)); // 3 boundary -> ABORT
      vecs.push_back(mk(0,0,0,0,0, S_SAVE|F_ACK,  0,     2'b01, 1)); // 4 SAVE
      vecs.push_back(mk(0,0,0,0,0, S_REDIR,       V_IRQ, 2'b00, 0)); // 5 REDIRECT
      vecs.push_back(mk(0,0,0,1,0, S_HAND,        0,     2'b00, 0)); // 6 HANDLER
      vecs.push_back(mk(1,0,0,1,0, S_HAND,        0,     2'b00, 0)); // 7 irq latched in handler
      vecs.push_back(mk(0,1,0,1,0, S_HAND,        0,     2'b00, 0)); // 8 undef ignored in handler
      vecs.push_back(mk(0,0,0,1,1, 7'd0,          0,     2'b00, 0)); // 9 eret -> IDLE
      // Undef beats pending irq
      vecs.push_back(mk(0,1,1,0,0, S_ABORT,       0,     2'b00, 0)); // 10
      vecs.push_back(mk(0,0,0,0,0, S_SAVE,        0,     2'b10, 1)); // 11 no ack
      vecs.push_back(mk(0,0,0,0,0, S_REDIR,       V_EXC, 2'b00, 0)); // 12
      vecs.push_back(mk(0,0,0,1,0, S_HAND,        0,     2'b00, 0)); // 13
      vecs.push_back(mk(0,0,0,1,1, 7'd0,          0,     2'b00, 0)); // 14
      // Deferred irq taken at next boundary
      vecs.push_back(mk(0,0,0,0,0, 7'd0,          0,     2'b00, 0)); // 15
      vecs.push_back(mk(0,0,1,0,0, S_ABORT,       0,     2'b00, 0)); // 16
      vecs.push_back(mk(0,0,0,0,0, S_SAVE|F_ACK,  0,     2'b01, 1)); // 17
      vecs.push_back(mk(0,0,0,0,0, S_REDIR,       V_IRQ, 2'b00, 0)); // 18
      vecs.push_back(mk(0,0,0,1,1, S_HAND,        0,     2'b00, 0)); // 19 eret in REDIRECT ignored
      vecs.push_back(mk(0,0,0,1,1, 7'd0,          0,     2'b00, 0)); // 20
      vecs.push_back(mk(0,0,0,0,1, 7'd0,          0,     2'b00, 0)); // 21 stray eret
      // Kernel-mode fault
      vecs.push_back(mk(0,1,0,1,0, F_DF,          0,     2'b11, 0)); // 22
      vecs.push_back(mk(0,0,0,0,0, F_DF,          0,     2'b11, 0)); // 23 sticky
      vecs.push_back(mk(1,0,1,1,0, F_DF,          0,     2'b11, 0)); // 24 irq blocked in kernel
      vecs.push_back(mk(0,0,1,1,0, F_DF,          0,     2'b11, 0)); // 25

      // Reset held with irq high
      drive(1,0,0,0,0);
      reset = 1'b0;
      #1;
      chk_idle("reset async");
      repeat (2) @(posedge clk);
      #1;
      chk_idle("reset held");
      @(negedge clk);
      reset = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("post-reset busy", 32'(busy), 32'd0);
      end

      // Table
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].irq, vecs[i].undef, vecs[i].bnd, vecs[i].kern, vecs[i].eret);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d flags", i), 32'(flags_now()), 32'(vecs[i].flags));
         chk($sformatf("vec%0d er_target", i), 32'(er_target),
             vecs[i].flags[4] ? 32'd26 : 32'd0);
         chk($sformatf("vec%0d handler_pc", i), handler_pc, vecs[i].hpc);
`ifdef EXC_CAUSE_EN
         chk($sformatf("vec%0d cause_code", i), 32'(cause_code), 32'(vecs[i].cc));
         chk($sformatf("vec%0d cause_write", i), 32'(cause_write), 32'(vecs[i].cw));
`endif
      end

      // Reset clears sticky fault and pending irq
      @(negedge clk);
      drive(0,0,0,0,0);
      reset = 1'b0;
      #1;
      chk_idle("reset clears fault");
      @(negedge clk);
      reset = 1'b1;
      drive(0,0,1,0,0);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("pend cleared by reset", 32'(flags_now()), 32'd0);
      end

      // Reset during SAVE
      @(negedge clk); drive(1,0,0,0,0);
      @(negedge clk); drive(0,0,1,0,0);
      @(posedge clk); #1;
      chk("mid abort", 32'(flags_now()), 32'(S_ABORT));
      @(negedge clk); drive(0,0,0,0,0);
      @(posedge clk); #1;
      chk("mid save", 32'(flags_now()), 32'(S_SAVE | F_ACK));
      #2 reset = 1'b0;
      #1;
      chk_idle("reset in save");
      @(negedge clk);
      reset = 1'b1;
      drive(0,0,1,0,0);
      repeat (4) begin
         @(posedge clk);
         #1;
         chk("no redirect after reset", 32'(flags_now()), 32'd0);
         chk("no handler_pc after reset", handler_pc, 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
